alu_pipe: RTL

//  Parametrised, 2-stage pipelined successor to the team's combinational 16-bit ALU.

---
 rtl/alu_pipe_if.sv | 26 ++
 rtl/alu_pipe.sv | 113 +++++++++++
 2 files changed

// File: rtl/alu_pipe_if.sv
// Handshake bundle between operand fetch, the ALU pipe and the writeback arbiter.
// master = the upstream/downstream environment, slave = the ALU pipe itself.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       inputA;
  logic [WIDTH-1:0]       inputB;
  logic [2:0]             opcode;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     result;
  logic [1:0]             flags;
  logic                   out_err;

  modport master (
    output in_valid, inputA, inputB, opcode, out_ready,
    input  in_ready, out_valid, result, flags, out_err
  );

  modport slave (
    input  in_valid, inputA, inputB, opcode, out_ready,
    output in_ready, out_valid, result, flags, out_err
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready backpressure on both sides.
// S1 captures operands and opcode; S2 computes and holds the output beat.
// Flags: [0] carry / borrow / mul-overflow, [1] signed overflow.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      rst_n,
  alu_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_MUL = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_NOT = 3'b110,
    OP_ILL = 3'b111
  } op_e;

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  op_e                s1_op;

  logic               s2_load;
  logic               s1_load;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;

  logic [2*WIDTH-1:0] res_c;
  logic [1:0]         flags_c;
  logic               err_c;

  // S2 may take a new beat when it is empty or its beat leaves this edge;
  // in_ready is derived only from pipe state and out_ready, never from in_valid.
  assign s2_load      = !bus.out_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  // S1: capture operands on an accepted input beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a  <= bus.inputA;
        s1_b  <= bus.inputB;
        s1_op <= op_e'(bus.opcode);
      end
    end
  end

  // Extra top bit of sum/diff carries the carry-out / borrow
  assign sum  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff = {1'b0, s1_a} - {1'b0, s1_b};
  assign prod = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};

  // Operation decode and flag generation for the beat held in S1
  always_comb begin
    res_c   = '0;
    flags_c = 2'b00;
    err_c   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res_c      = {{(WIDTH-1){1'b0}}, sum};
        flags_c[0] = sum[WIDTH];
        flags_c[1] = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_MUL: begin
        res_c      = prod;
        flags_c[0] = |prod[2*WIDTH-1:WIDTH];
      end
      OP_SUB: begin
        res_c      = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
        flags_c[0] = diff[WIDTH];
        flags_c[1] = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_AND:  res_c = {{WIDTH{1'b0}}, s1_a & s1_b};
      OP_OR:   res_c = {{WIDTH{1'b0}}, s1_a | s1_b};
      OP_XOR:  res_c = {{WIDTH{1'b0}}, s1_a ^ s1_b};
      OP_NOT:  res_c = {{WIDTH{1'b0}}, ~s1_a};
      OP_ILL:  err_c = 1'b1;
      default: err_c = 1'b1;
    endcase
  end

  // S2: register the computed beat; hold everything while stalled downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.flags     <= 2'b00;
      bus.out_err   <= 1'b0;
    end else if (s2_load) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.result  <= res_c;
        bus.flags   <= flags_c;
        bus.out_err <= err_c;
      end
    end
  end

endmodule
